curr_ctrl_debug_capture: RTL and testbench
==========================================

# curr_ctrl_debug_capture

Trace-capture engine that drives the write-side port of the current-control 512 × 32 dual-port debug RAM. It streams controller samples into the RAM as a circular buffer, stops a programmable number of samples after a trigger, and then freezes the buffer. Software reads the frozen buffer through the RAM's other port. It sits between the current-control datapath and port 2 of the debug RAM.

## Interface
- `ADDR_W`, default 9: RAM word address width, giving a depth of 512.
- `DATA_W`, default 32: sample and RAM word width.

Ports:
- `clk`  in  1  clock for the capture engine and the RAM write port.
- `reset_n`  in  1  synchronous, active-low reset.
- `arm`  in  1  one-cycle pulse that starts a capture.
- `abort`  in  1  one-cycle pulse that cancels a capture.
- `post_len`  in  ADDR_W  number of samples to store after the trigger sample; latched on `arm`.
- `sample_valid`  in  1  `sample_data` is valid this cycle.
- `sample_data`  in  DATA_W  controller sample.
- `trig_in`  in  1  trigger condition; qualified by `sample_valid`.
- `ram_address`  out  ADDR_W  RAM write address.
- `ram_chipselect`  out  1  RAM select; equals `ram_write`.
- `ram_write`  out  1  write strobe, one cycle per sample.
- `ram_byteenable`  out  DATA_W/8  constant all-ones.
- `ram_writedata`  out  DATA_W  word to write.
- `ram_clken`  out  1  constant 1.
- `armed`  out  1  high in PRETRIG or POSTTRIG.
- `triggered`  out  1  high in POSTTRIG or DONE.
- `done`  out  1  high in DONE (buffer frozen).
- `wrapped`  out  1  the write pointer has passed address 511 at least once since `arm`.
- `trig_addr`  out  ADDR_W  RAM address of the trigger sample.
- `last_addr`  out  ADDR_W  address of the most recent write.

## Operation
The engine has four states: IDLE, PRETRIG, POSTTRIG and DONE.

- **IDLE**
  - `arm` moves to PRETRIG.
  - On `arm`: write pointer `wp` ← 0, `wrapped` ← 0, `post_len` latched into `post_cnt`.
- **PRETRIG**
  - Each `sample_valid` writes the sample at `wp`, then `wp` ← `wp`+1 mod 512.
  - When `wp` rolls from 511 to 0, `wrapped` ← 1.
  - `sample_valid & trig_in` marks that sample as the trigger sample.
    - The trigger sample is written.
    - `trig_addr` ← `wp`.
    - If `post_cnt`==0, go to DONE; otherwise go to POSTTRIG.
- **POSTTRIG**
  - Each `sample_valid` writes the sample and decrements `post_cnt`.
  - The write that takes `post_cnt` to 0 moves the engine to DONE.
  - `trig_in` is ignored.
- **DONE**
  - No writes.
  - `ram_write` stays 0 until `arm` or `abort`.
  - `arm` restarts the capture exactly as it does from IDLE.
- **Abort and priority**
  - `abort` in any state moves to IDLE and clears `triggered`. It does not set `done`.
  - `abort` has priority over `arm`.
  - `arm` has priority over a same-cycle trigger or sample: that sample is not written.
  - `arm` while in PRETRIG or POSTTRIG restarts the capture.
- **Write limit**
  - `post_len` is at most 511, so the trigger sample is never overwritten.
  - Total writes after the trigger = `post_len`.
- **`last_addr`**
  - Updates with every write.
  - Holds its value in DONE and IDLE.
- **Reset values**
  - All status outputs reset to 0: `armed`, `triggered`, `done`, `wrapped`, `trig_addr`, `last_addr`.
  - RAM outputs: `ram_write`=`ram_chipselect`=0, `ram_address`=0, `ram_writedata`=0.
  - `ram_byteenable`=all-ones and `ram_clken`=1, both constant.
  - Reset state is IDLE.

## Timing
- **Write latency**
  - All RAM-side outputs are registered.
  - A sample accepted at edge N produces `ram_write`=1, `ram_address`=`wp`, `ram_writedata`=sample during cycle N+1.
  - The RAM captures that write at edge N+2.
- **Throughput**: one write per cycle. Back-to-back `sample_valid` gives back-to-back writes, with no stall and no waitrequest.
- **Status timing**
  - `armed` rises the cycle after `arm`.
  - `triggered` and `trig_addr` update the cycle after the trigger sample.
  - `done` rises in the same cycle as the final `ram_write` strobe. Software must wait one further cycle before reading the last word.
- **Reset mid-capture**: `reset_n` low at any edge aborts and returns the engine to IDLE. No write is issued in the cycle after reset.

## Configuration
- `CURRCTRL_DBG_SEQNUM_EN` defined:
  - `ram_writedata[31:24]` = 8-bit sequence number. It is cleared on `arm` and increments per written sample, wrapping 255→0.
  - `ram_writedata[23:0]` = `sample_data[23:0]`.
- `CURRCTRL_DBG_SEQNUM_EN` undefined:
  - `ram_writedata` = `sample_data` unmodified.
  - No sequence counter is present.

## Test plan
- **Basic post-trigger capture**
  - Stimulus: `arm` with `post_len`=4; 10 valid samples 0x100..0x109; `trig_in` on 0x105.
  - Required: writes to addresses 0..9; `trig_addr`=5; `done` rises on the write to address 9; `wrapped`=0.
- **Wrap**
  - Stimulus: `arm` with `post_len`=10; 600 samples valued 0..599; trigger on sample 550.
  - Required: `wrapped`=1; `trig_addr`=38; `last_addr`=48; no write after `done`.
- **Zero post_len**
  - Stimulus: `post_len`=0; trigger on the first sample.
  - Required: exactly one write, at address 0; `done` asserted in the same cycle as that strobe.
- **Priority**
  - Stimulus: `arm` and `sample_valid&trig_in` in the same cycle while in PRETRIG.
  - Required: capture restarts; that sample is not written; the next sample is written at address 0.
- **Abort and reset**
  - Stimulus: `abort` during POSTTRIG; then, in a separate run, `reset_n`=0 during POSTTRIG.
  - Required in both runs: IDLE; `ram_write`=0 the next cycle; `done`=0; `triggered`=0.
- **Gapped samples and sequence numbers**
  - Stimulus: `sample_valid` toggling 1-0-1-0; build run with `CURRCTRL_DBG_SEQNUM_EN` defined.
  - Required: writes only on valid cycles; `ram_writedata[31:24]` = 0, 1, 2, …; `[23:0]` matches the samples.

Source files
------------

// File: rtl/curr_ctrl_debug_capture.sv
// Trace capture engine: circular write into the debug RAM, freeze after trigger.
// Optional build macro CURRCTRL_DBG_SEQNUM_EN puts a sequence number in data[31:24].
module curr_ctrl_debug_capture #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  arm,
  input  logic                  abort,
  input  logic [ADDR_W-1:0]     post_len,
  input  logic                  sample_valid,
  input  logic [DATA_W-1:0]     sample_data,
  input  logic                  trig_in,
  output logic [ADDR_W-1:0]     ram_address,
  output logic                  ram_chipselect,
  output logic                  ram_write,
  output logic [DATA_W/8-1:0]   ram_byteenable,
  output logic [DATA_W-1:0]     ram_writedata,
  output logic                  ram_clken,
  output logic                  armed,
  output logic                  triggered,
  output logic                  done,
  output logic                  wrapped,
  output logic [ADDR_W-1:0]     trig_addr,
  output logic [ADDR_W-1:0]     last_addr
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRE,
    S_POST,
    S_DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [ADDR_W-1:0] wp;
  logic [ADDR_W-1:0] post_cnt;
  logic              in_cap;
  logic              wr_en;
  logic              trig_hit;
  logic              arm_go;
  logic [DATA_W-1:0] wdata;

  assign in_cap   = (state == S_PRE) || (state == S_POST);
  assign arm_go   = arm && !abort;
  assign wr_en    = in_cap && sample_valid && !arm && !abort;
  assign trig_hit = (state == S_PRE) && wr_en && trig_in;

  assign ram_chipselect = ram_write;
  assign ram_byteenable = '1;
  assign ram_clken      = 1'b1;

`ifdef CURRCTRL_DBG_SEQNUM_EN
  logic [7:0] seq;

  // Sequence number of the next written sample, restarted by arm.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      seq <= '0;
    end else if (arm_go) begin
      seq <= '0;
    end else if (wr_en) begin
      seq <= seq + 8'd1;
    end
  end

  assign wdata = {seq, sample_data[DATA_W-9:0]};
`else
  assign wdata = sample_data;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: abort beats arm, arm beats any sample or trigger.
  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = S_IDLE;
    end else if (arm) begin
      state_nxt = S_PRE;
    end else begin
      case (state)
        S_PRE: begin
          if (trig_hit) begin
            state_nxt = (post_cnt == '0) ? S_DONE : S_POST;
          end
        end
        S_POST: begin
          if (wr_en && post_cnt == ADDR_W'(1)) begin
            state_nxt = S_DONE;
          end
        end
        default: state_nxt = state;
      endcase
    end
  end

  // Status flags decoded from the registered state.
  always_comb begin
    armed     = in_cap;
    triggered = (state == S_POST) || (state == S_DONE);
    done      = (state == S_DONE);
  end

  // Write pointer, counters and registered RAM write port.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wp            <= '0;
      post_cnt      <= '0;
      wrapped       <= 1'b0;
      trig_addr     <= '0;
      last_addr     <= '0;
      ram_write     <= 1'b0;
      ram_address   <= '0;
      ram_writedata <= '0;
    end else begin
      ram_write <= wr_en;
      if (arm_go) begin
        wp       <= '0;
        wrapped  <= 1'b0;
        post_cnt <= post_len;
      end else if (wr_en) begin
        ram_address   <= wp;
        ram_writedata <= wdata;
        last_addr     <= wp;
        wp            <= wp + ADDR_W'(1);
        if (&wp) begin
          wrapped <= 1'b1;
        end
        if (trig_hit) begin
          trig_addr <= wp;
        end
        if (state == S_POST) begin
          post_cnt <= post_cnt - ADDR_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_curr_ctrl_debug_capture.sv
// Directed bench for curr_ctrl_debug_capture.
// Writes are logged on the falling edge and checked per scenario.
module tb_curr_ctrl_debug_capture;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        arm;
  logic        abort;
  logic [8:0]  post_len;
  logic        sample_valid;
  logic [31:0] sample_data;
  logic        trig_in;
  logic [8:0]  ram_address;
  logic        ram_chipselect;
  logic        ram_write;
  logic [3:0]  ram_byteenable;
  logic [31:0] ram_writedata;
  logic        ram_clken;
  logic        armed;
  logic        triggered;
  logic        done;
  logic        wrapped;
  logic [8:0]  trig_addr;
  logic [8:0]  last_addr;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [512];
  int          wr_count;
  int          wr_after_done;
  int          cs_bad;
  logic [8:0]  last_wr_addr;
  logic        done_on_last;
  logic        prev_done;

  curr_ctrl_debug_capture #(.ADDR_W(9), .DATA_W(32)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .arm            (arm),
    .abort          (abort),
    .post_len       (post_len),
    .sample_valid   (sample_valid),
    .sample_data    (sample_data),
    .trig_in        (trig_in),
    .ram_address    (ram_address),
    .ram_chipselect (ram_chipselect),
    .ram_write      (ram_write),
    .ram_byteenable (ram_byteenable),
    .ram_writedata  (ram_writedata),
    .ram_clken      (ram_clken),
    .armed          (armed),
    .triggered      (triggered),
    .done           (done),
    .wrapped        (wrapped),
    .trig_addr      (trig_addr),
    .last_addr      (last_addr)
  );

  always #5 clk = ~clk;

  // Write logger: a model RAM plus counters.
  always @(negedge clk) begin
    if (ram_write === 1'b1) begin
      mem[ram_address] = ram_writedata;
      wr_count++;
      last_wr_addr = ram_address;
      done_on_last = done;
      if (prev_done === 1'b1) wr_after_done++;
    end
    if (ram_chipselect !== ram_write) cs_bad++;
    prev_done = done;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    for (int i = 0; i < 512; i++) mem[i] = 32'hDEAD_BEEF;
    wr_count      = 0;
    wr_after_done = 0;
    cs_bad        = 0;
    last_wr_addr  = '0;
    done_on_last  = 1'b0;
  endtask

  task automatic do_arm(input logic [8:0] len);
    arm      = 1'b1;
    post_len = len;
    tick();
    arm = 1'b0;
  endtask

  task automatic send(input logic [31:0] d, input logic t);
    sample_valid = 1'b1;
    sample_data  = d;
    trig_in      = t;
    tick();
    sample_valid = 1'b0;
    trig_in      = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    checks++;
    if ({armed, triggered, done, wrapped} !== 4'b0) begin
      errors++;
      $display("FAIL reset_flags got %b exp 0000", {armed, triggered, done, wrapped});
    end
    checks++;
    if (trig_addr !== 9'd0 || last_addr !== 9'd0) begin
      errors++;
      $display("FAIL reset_addrs got %0d/%0d exp 0/0", trig_addr, last_addr);
    end
    checks++;
    if (ram_write !== 1'b0 || ram_chipselect !== 1'b0) begin
      errors++;
      $display("FAIL reset_wr got %b%b exp 00", ram_write, ram_chipselect);
    end
    checks++;
    if (ram_address !== 9'd0 || ram_writedata !== 32'd0) begin
      errors++;
      $display("FAIL reset_ram got %0h/%0h exp 0/0", ram_address, ram_writedata);
    end
    checks++;
    if (ram_byteenable !== 4'hF || ram_clken !== 1'b1) begin
      errors++;
      $display("FAIL reset_const got %h/%b exp f/1", ram_byteenable, ram_clken);
    end
  endtask

  task automatic test_basic();
    int bad;
    clear_log();
    do_arm(9'd4);
    checks++;
    if (armed !== 1'b1) begin
      errors++;
      $display("FAIL basic_armed got %b exp 1", armed);
    end
    for (int i = 0; i < 10; i++) begin
      send(32'h100 + i, i == 5);
      if (i == 8) begin
        checks++;
        if (done !== 1'b0) begin
          errors++;
          $display("FAIL basic_done_early got %b exp 0", done);
        end
      end
    end
    checks++;
    if (done !== 1'b1 || ram_write !== 1'b1 || ram_address !== 9'd9) begin
      errors++;
      $display("FAIL basic_done_edge got %b%b@%0d exp 11@9", done, ram_write, ram_address);
    end
    tick();
    tick();
    bad = 0;
    for (int i = 0; i < 10; i++) if (mem[i] !== 32'h100 + i) bad++;
    checks++;
    if (bad != 0 || wr_count != 10) begin
      errors++;
      $display("FAIL basic_mem got bad=%0d n=%0d exp 0/10", bad, wr_count);
    end
    checks++;
    if (trig_addr !== 9'd5 || triggered !== 1'b1) begin
      errors++;
      $display("FAIL basic_trig got %0d/%b exp 5/1", trig_addr, triggered);
    end
    checks++;
    if (wrapped !== 1'b0 || armed !== 1'b0 || last_addr !== 9'd9) begin
      errors++;
      $display("FAIL basic_status got %b/%b/%0d exp 0/0/9", wrapped, armed, last_addr);
    end
  endtask

  task automatic test_wrap();
    clear_log();
    do_arm(9'd10);
    for (int k = 0; k < 600; k++) send(32'(k), k == 550);
    tick();
    tick();
    checks++;
    if (wrapped !== 1'b1) begin
      errors++;
      $display("FAIL wrap_flag got %b exp 1", wrapped);
    end
    checks++;
    if (trig_addr !== 9'd38 || last_addr !== 9'd48) begin
      errors++;
      $display("FAIL wrap_addrs got %0d/%0d exp 38/48", trig_addr, last_addr);
    end
    checks++;
    if (wr_count != 561 || wr_after_done != 0) begin
      errors++;
      $display("FAIL wrap_count got %0d/%0d exp 561/0", wr_count, wr_after_done);
    end
    checks++;
    if (mem[38] !== 32'd550 || mem[48] !== 32'd560 || mem[49] !== 32'd49) begin
      errors++;
      $display("FAIL wrap_mem got %0d/%0d/%0d exp 550/560/49", mem[38], mem[48], mem[49]);
    end
    checks++;
    if (cs_bad != 0) begin
      errors++;
      $display("FAIL wrap_cs got %0d exp 0", cs_bad);
    end
  endtask

  task automatic test_zero_post();
    clear_log();
    do_arm(9'd0);
    send(32'hABC, 1'b1);
    checks++;
    if (ram_write !== 1'b1 || done !== 1'b1 || ram_address !== 9'd0) begin
      errors++;
      $display("FAIL zero_edge got %b%b@%0d exp 11@0", ram_write, done, ram_address);
    end
    send(32'hDEF, 1'b0);
    send(32'h123, 1'b1);
    tick();
    checks++;
    if (wr_count != 1 || mem[0] !== 32'hABC || wr_after_done != 0) begin
      errors++;
      $display("FAIL zero_count got %0d/%0h exp 1/abc", wr_count, mem[0]);
    end
    checks++;
    if (triggered !== 1'b1 || trig_addr !== 9'd0 || done !== 1'b1) begin
      errors++;
      $display("FAIL zero_status got %b/%0d/%b exp 1/0/1", triggered, trig_addr, done);
    end
  endtask

  task automatic test_priority();
    clear_log();
    do_arm(9'd3);
    send(32'h11, 1'b0);
    send(32'h22, 1'b0);
    arm          = 1'b1;
    post_len     = 9'd3;
    sample_valid = 1'b1;
    trig_in      = 1'b1;
    sample_data  = 32'h33;
    tick();
    arm          = 1'b0;
    sample_valid = 1'b0;
    trig_in      = 1'b0;
    checks++;
    if (ram_write !== 1'b0 || armed !== 1'b1 || triggered !== 1'b0) begin
      errors++;
      $display("FAIL prio_arm got %b/%b/%b exp 0/1/0", ram_write, armed, triggered);
    end
    send(32'h44, 1'b0);
    checks++;
    if (ram_write !== 1'b1 || ram_address !== 9'd0 || ram_writedata !== 32'h44) begin
      errors++;
      $display("FAIL prio_next got %b@%0d=%0h exp 1@0=44", ram_write, ram_address, ram_writedata);
    end
  endtask

  task automatic test_gapped();
    logic [31:0] d;
    logic [31:0] exp_d;
    clear_log();
    do_arm(9'd20);
    for (int i = 0; i < 6; i++) begin
      d = 32'h5AA0_0000 + 32'(i);
      sample_valid = (i % 2 == 0);
      sample_data  = d;
      tick();
      sample_valid = 1'b0;
`ifdef CURRCTRL_DBG_SEQNUM_EN
      exp_d = {8'(i / 2), d[23:0]};
`else
      exp_d = d;
`endif
      checks++;
      if (ram_write !== (i % 2 == 0)) begin
        errors++;
        $display("FAIL gap_wr%0d got %b exp %b", i, ram_write, (i % 2 == 0));
      end
      if (i % 2 == 0) begin
        checks++;
        if (ram_writedata !== exp_d || ram_address !== 9'(i / 2)) begin
          errors++;
          $display("FAIL gap_data%0d got %h@%0d exp %h@%0d", i, ram_writedata, ram_address, exp_d, i / 2);
        end
      end
    end
  endtask

  task automatic test_abort_reset();
    do_arm(9'd5);
    send(32'h1, 1'b1);
    send(32'h2, 1'b0);
    abort        = 1'b1;
    sample_valid = 1'b1;
    sample_data  = 32'h3;
    tick();
    abort        = 1'b0;
    sample_valid = 1'b0;
    checks++;
    if ({ram_write, done, triggered, armed} !== 4'b0) begin
      errors++;
      $display("FAIL abort_state got %b exp 0000", {ram_write, done, triggered, armed});
    end
    send(32'h9, 1'b1);
    checks++;
    if (ram_write !== 1'b0 || armed !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle got %b/%b exp 0/0", ram_write, armed);
    end
    do_arm(9'd5);
    send(32'h1, 1'b1);
    send(32'h2, 1'b0);
    reset_n      = 1'b0;
    sample_valid = 1'b1;
    sample_data  = 32'h3;
    tick();
    reset_n      = 1'b1;
    sample_valid = 1'b0;
    checks++;
    if ({ram_write, done, triggered, armed} !== 4'b0) begin
      errors++;
      $display("FAIL rst_state got %b exp 0000", {ram_write, done, triggered, armed});
    end
    checks++;
    if (trig_addr !== 9'd0 || last_addr !== 9'd0) begin
      errors++;
      $display("FAIL rst_addrs got %0d/%0d exp 0/0", trig_addr, last_addr);
    end
  endtask

  initial begin
    reset_n      = 1'b0;
    arm          = 1'b0;
    abort        = 1'b0;
    post_len     = '0;
    sample_valid = 1'b0;
    sample_data  = '0;
    trig_in      = 1'b0;
    prev_done    = 1'b0;
    clear_log();
    test_reset();
    test_basic();
    test_wrap();
    test_zero_post();
    test_priority();
    test_gapped();
    test_abort_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
